hdmi_island_scheduler: RTL and testbench

//  Sequences HDMI data islands in horizontal blanking and arbitrates packet slots between four packet sources.

---
 rtl/hdmi_island_pkg.sv | 25 ++
 rtl/hdmi_island_arbiter.sv | 32 +++
 rtl/hdmi_island_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_hdmi_island_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_island_pkg.sv
// hdmi_island_pkg: shared types and constants for the HDMI data-island scheduler.
//   phase_e  - island phase encoding, also driven out on o_phase
//   SRC_*    - packet source ids used by o_sel and bit positions of i_req/o_ack
//   *_LEN    - fixed phase lengths in pixel clocks
package hdmi_island_pkg;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_WAIT     = 3'd1,
    PH_PRE      = 3'd2,
    PH_GLEAD    = 3'd3,
    PH_PKT      = 3'd4,
    PH_GTRAIL   = 3'd5
  } phase_e;

  localparam logic [1:0] SRC_ACR = 2'd0;
  localparam logic [1:0] SRC_AUD = 2'd1;
  localparam logic [1:0] SRC_AVI = 2'd2;
  localparam logic [1:0] SRC_AIF = 2'd3;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PKT_LEN      = 32;

endpackage

// File: rtl/hdmi_island_arbiter.sv
// hdmi_pkt_arbiter: combinational slot winner selection.
//   req     - live requests, one bit per source
//   excl    - sources already granted in this island
//   rr_aif  - infoframe round-robin pointer (0 = AVI next, 1 = audio IF next)
//   win_id  - winning source id
//   win_vld - at least one eligible request
// Priority is ACR > audio sample > infoframe; the two infoframes share the
// lowest level and are split by the pointer, which the caller owns.
module hdmi_pkt_arbiter
  import hdmi_island_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] excl,
  input  logic       rr_aif,
  output logic [1:0] win_id,
  output logic       win_vld
);

  logic [3:0] elig;

  always_comb begin
    elig    = req & ~excl;
    win_id  = SRC_ACR;
    win_vld = |elig;
    if (elig[SRC_ACR])                    win_id = SRC_ACR;
    else if (elig[SRC_AUD])               win_id = SRC_AUD;
    else if (elig[SRC_AVI] && elig[SRC_AIF]) win_id = rr_aif ? SRC_AIF : SRC_AVI;
    else if (elig[SRC_AVI])               win_id = SRC_AVI;
    else if (elig[SRC_AIF])               win_id = SRC_AIF;
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler: sequences one HDMI data island per horizontal
// blanking interval and hands its packet slots to four packet sources.
//   i_pixclk/i_rst_n - pixel clock, async active-low reset
//   i_blank, i_hSync - timing from the video timing generator
//   i_enable         - islands allowed
//   i_req[3:0]       - hold-until-ack requests (ACR, audio, AVI IF, audio IF)
//   o_ack[3:0]       - one-cycle grant on the first cycle of a slot
//   o_sel            - source of the current slot
//   o_phase          - current island phase (see hdmi_island_pkg::phase_e)
//   o_data_en        - TERC4 period (guards and packets)
//   o_pkt_idx        - bit index within the current packet
//   o_pkt_first      - current slot is the first of the island
//   o_abort          - island cut short by blanking ending
module hdmi_island_scheduler
  import hdmi_island_pkg::*;
#(
  parameter int MAX_PKTS  = 2,
  parameter int PRE_DELAY = 4
) (
  input  logic       i_pixclk,
  input  logic       i_rst_n,
  input  logic       i_blank,
  input  logic       i_hSync,
  input  logic       i_enable,
  input  logic [3:0] i_req,
  output logic [3:0] o_ack,
  output logic [1:0] o_sel,
  output logic [2:0] o_phase,
  output logic       o_data_en,
  output logic [4:0] o_pkt_idx,
  output logic       o_pkt_first,
  output logic       o_abort
);

  localparam logic [7:0] WAIT_LAST = 8'(PRE_DELAY - 1);
  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GRD_LAST  = 8'(GUARD_LEN - 1);
  localparam logic [4:0] BIT_LAST  = 5'(PKT_LEN - 1);
  localparam logic [2:0] SLOT_LAST = 3'(MAX_PKTS - 1);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d;
  logic [2:0] slot_q, slot_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] excl_q, excl_d;
  logic       rr_q, rr_d;
  logic       armed_q, armed_d;
  logic       blank_q, hsync_q;

  logic       abort, trigger, ack_now, in_pkt;
  logic [3:0] arb_excl;
  logic [1:0] arb_id;
  logic       arb_vld;

  // Between islands excl_q holds the previous island's grants; slot 0 sees none.
  assign arb_excl = (phase_q == PH_IDLE) ? 4'b0000 : excl_q;

  hdmi_pkt_arbiter u_arb (
    .req     (i_req),
    .excl    (arb_excl),
    .rr_aif  (rr_q),
    .win_id  (arb_id),
    .win_vld (arb_vld)
  );

  // Blanking ending cuts the island in the same cycle, before any register.
  assign abort   = (phase_q != PH_IDLE) && !i_blank;
  assign trigger = armed_q && (i_hSync ^ hsync_q) && (phase_q == PH_IDLE);
  assign in_pkt  = (phase_q == PH_PKT) && !abort;
  assign ack_now = in_pkt && (bit_q == 5'd0);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    sel_d   = sel_q;
    excl_d  = excl_q;
    rr_d    = rr_q;
    armed_d = armed_q;

    if (i_blank && !blank_q) armed_d = 1'b1;
    if (trigger)             armed_d = 1'b0;

    // Grant bookkeeping happens on the ack cycle; sel_q[1] marks an infoframe.
    if (ack_now) begin
      excl_d = excl_q | (4'b0001 << sel_q);
      if (sel_q[1]) rr_d = ~rr_q;
    end

    unique case (phase_q)
      PH_IDLE: begin
        if (trigger && i_enable && arb_vld) begin
          sel_d   = arb_id;
          excl_d  = 4'b0000;
          slot_d  = 3'd0;
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
          phase_d = (PRE_DELAY == 0) ? PH_PRE : PH_WAIT;
        end
      end
      PH_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 8'd0;
          phase_d = PH_PRE;
        end
      end
      PH_PRE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = 8'd0;
          phase_d = PH_GLEAD;
        end
      end
      PH_GLEAD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GRD_LAST) begin
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
          phase_d = PH_PKT;
        end
      end
      PH_PKT: begin
        bit_d = bit_q + 5'd1;
        // Next slot is chosen on the last bit from that cycle's requests;
        // bit_d wraps to 0 so consecutive slots abut with no guard.
        if (bit_q == BIT_LAST) begin
          if ((slot_q < SLOT_LAST) && arb_vld) begin
            sel_d  = arb_id;
            slot_d = slot_q + 3'd1;
          end else begin
            cnt_d   = 8'd0;
            phase_d = PH_GTRAIL;
          end
        end
      end
      PH_GTRAIL: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GRD_LAST) begin
          cnt_d   = 8'd0;
          phase_d = PH_IDLE;
        end
      end
      default: phase_d = PH_IDLE;
    endcase

    if (abort) begin
      phase_d = PH_IDLE;
      cnt_d   = 8'd0;
      bit_d   = 5'd0;
    end
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      slot_q  <= 3'd0;
      sel_q   <= SRC_ACR;
      excl_q  <= 4'b0000;
      rr_q    <= 1'b0;
      armed_q <= 1'b0;
      // Reset as "blank already high" so a line that is mid-blank when reset
      // releases cannot arm; a fresh 0->1 edge is required.
      blank_q <= 1'b1;
      hsync_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      sel_q   <= sel_d;
      excl_q  <= excl_d;
      rr_q    <= rr_d;
      armed_q <= armed_d;
      blank_q <= i_blank;
      hsync_q <= i_hSync;
    end
  end

  assign o_phase     = abort ? 3'd0 : phase_q;
  assign o_data_en   = !abort && ((phase_q == PH_GLEAD) || (phase_q == PH_PKT) ||
                                  (phase_q == PH_GTRAIL));
  assign o_ack       = ack_now ? (4'b0001 << sel_q) : 4'b0000;
  assign o_sel       = in_pkt ? sel_q : 2'd0;
  assign o_pkt_idx   = in_pkt ? bit_q : 5'd0;
  assign o_pkt_first = in_pkt && (slot_q == 3'd0);
  assign o_abort     = abort;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
module tb_hdmi_island_scheduler;

  localparam int PD = 4;
  localparam int MP = 2;
  localparam int BASE = PD + 11;   // offset of slot 0 bit 0 from the trigger

  logic       clk = 0, rst_n = 0;
  logic       i_blank = 0, i_hSync = 0, i_enable = 0;
  logic [3:0] i_req = 0;
  logic [3:0] o_ack;
  logic [1:0] o_sel;
  logic [2:0] o_phase;
  logic       o_data_en, o_pkt_first, o_abort;
  logic [4:0] o_pkt_idx;

  hdmi_island_scheduler #(.MAX_PKTS(MP), .PRE_DELAY(PD)) dut (
    .i_pixclk(clk), .i_rst_n(rst_n), .i_blank(i_blank), .i_hSync(i_hSync),
    .i_enable(i_enable), .i_req(i_req), .o_ack(o_ack), .o_sel(o_sel),
    .o_phase(o_phase), .o_data_en(o_data_en), .o_pkt_idx(o_pkt_idx),
    .o_pkt_first(o_pkt_first), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: island described by its trigger offset and slot list.
  logic       m_armed, m_pb, m_phs, m_act, m_rr;
  int         m_k, m_ns;
  int         m_src [8];
  logic [3:0] m_gr;
  logic [3:0] pend;            // requester-side pending requests
  logic       hs;
  int         acklog [$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] late;
    logic       en;
    int         en_drop;
    int         abort_at;
    int         rst_at;
    int         code;          // grant sequence, (src+1) per nibble; -1 = unchecked
  } line_t;

  line_t lines [16];

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, m_k, got, exp);
    end
  endtask

  function automatic int win(logic [3:0] r, logic [3:0] g, logic rr);
    logic [3:0] e;
    e = r & ~g;
    if (e[0]) return 0;
    if (e[1]) return 1;
    if (e[2] && e[3]) return rr ? 3 : 2;
    if (e[2]) return 2;
    if (e[3]) return 3;
    return -1;
  endfunction

  function automatic int outs();
    return int'({o_phase, o_data_en, o_ack, o_sel, o_pkt_idx, o_pkt_first, o_abort});
  endfunction

  task automatic model_reset();
    m_armed = 0; m_pb = 1; m_phs = 0; m_act = 0; m_rr = 0;
    m_k = 0; m_ns = 0; m_gr = 0;
  endtask

  task automatic eval();
    logic [2:0] ph;
    logic [3:0] ack;
    logic [1:0] sel;
    logic [4:0] idx;
    logic       first, den, ab, was_act, trig;
    int         j, s, w;
    ph = 0; ack = 0; sel = 0; idx = 0; first = 0; den = 0;
    was_act = m_act;
    ab = m_act && !i_blank;
    if (m_act && !ab) begin
      if (m_k <= PD) ph = 1;
      else if (m_k <= PD + 8) ph = 2;
      else if (m_k <= PD + 10) ph = 3;
      else begin
        j = m_k - BASE;
        s = j / 32;
        if (s < m_ns) begin
          ph = 4; idx = 5'(j % 32); sel = 2'(m_src[s]); first = (s == 0);
          if (idx == 0) ack = 4'b0001 << sel;
        end else ph = 5;
      end
      den = (ph >= 3);
    end
    check("cycle", outs(), int'({ph, den, ack, sel, idx, first, ab}));

    trig = !was_act && m_armed && (i_hSync != m_phs);
    if (ab) m_act = 0;
    else if (m_act) begin
      if (ack != 0) begin
        m_gr |= ack;
        acklog.push_back(int'(sel));
        if (sel >= 2) m_rr = ~m_rr;
      end
      if (ph == 4 && idx == 31 && m_ns < MP) begin
        w = win(i_req, m_gr, m_rr);
        if (w >= 0) begin m_src[m_ns] = w; m_ns++; end
      end
      m_k++;
      if (m_k >= BASE + 32 * m_ns + 2) m_act = 0;
    end
    if (i_blank && !m_pb) m_armed = 1;
    if (trig) begin
      m_armed = 0;
      if (i_enable) begin
        w = win(i_req, 4'b0000, m_rr);
        if (w >= 0) begin
          m_act = 1; m_k = 1; m_ns = 1; m_src[0] = w; m_gr = 0;
        end
      end
    end
    m_pb = i_blank; m_phs = i_hSync;
    pend &= ~ack;                  // requester drops after its ack
  endtask

  task automatic step(input logic b, input logic en);
    @(negedge clk);
    i_blank = b; i_hSync = hs; i_enable = en; i_req = pend;
    #1;
    eval();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("async_rst", outs(), 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic do_line(input line_t v);
    logic b, en;
    int   code;
    pend |= v.req;
    acklog.delete();
    repeat (4) step(1'b0, v.en);
    repeat (3) step(1'b1, v.en);
    for (int k = 0; k < 95; k++) begin
      if (k == 0 || k == 40) hs = ~hs;
      if (k == 5) pend |= v.late;
      if (v.rst_at != 0 && k == v.rst_at) do_reset();
      b  = !(v.abort_at != 0 && k >= v.abort_at);
      en = v.en && !(v.en_drop != 0 && k >= v.en_drop);
      step(b, en);
    end
    if (v.code >= 0) begin
      code = 0;
      foreach (acklog[i]) code |= (acklog[i] + 1) << (4 * i);
      check("line_acks", code, v.code);
    end
  endtask

  line_t r;

  initial begin
    //          req      late     en  drop abort rst  code
    lines[0]  = '{4'b0011, 4'b0000, 1, 0,  0,  0, 'h21};  // ACR then audio
    lines[1]  = '{4'b1100, 4'b0000, 1, 0,  0,  0, 'h43};  // AVI then AIF
    lines[2]  = '{4'b1100, 4'b0000, 1, 0,  0,  0, 'h43};
    lines[3]  = '{4'b0000, 4'b0001, 1, 0,  0,  0, 'h0};   // no req at trigger
    lines[4]  = '{4'b0000, 4'b0000, 1, 0,  0,  0, 'h1};   // late ACR served now
    lines[5]  = '{4'b0111, 4'b0000, 1, 0,  0,  0, 'h21};  // AVI left pending
    lines[6]  = '{4'b0000, 4'b0000, 1, 0,  0,  0, 'h3};
    lines[7]  = '{4'b0011, 4'b0000, 1, 0, 30,  0, 'h1};   // abort in slot 0
    lines[8]  = '{4'b0000, 4'b0000, 1, 0,  0,  0, 'h2};
    lines[9]  = '{4'b1000, 4'b0000, 0, 0,  0,  0, 'h0};   // disabled
    lines[10] = '{4'b0000, 4'b0000, 1, 0,  0,  0, 'h4};
    lines[11] = '{4'b0100, 4'b0000, 1, 0,  3,  0, 'h0};   // abort in WAIT
    lines[12] = '{4'b0000, 4'b0000, 1, 0,  0,  0, 'h3};
    lines[13] = '{4'b0011, 4'b0000, 1, 10, 0,  0, 'h21};  // enable drops mid-island
    lines[14] = '{4'b0011, 4'b0000, 1, 0,  0, 20, 'h1};   // async reset at T+20
    lines[15] = '{4'b0000, 4'b0000, 1, 0,  0,  0, 'h2};

    pend = 0; hs = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_outs", outs(), 0);
    @(negedge clk) rst_n = 1;

    foreach (lines[i]) do_line(lines[i]);

    for (int n = 0; n < 20; n++) begin
      r.req      = 4'($urandom_range(0, 15));
      r.late     = 4'($urandom_range(0, 15)) & {3'b000, ($urandom_range(0, 3) == 0)};
      r.en       = ($urandom_range(0, 7) != 0);
      r.en_drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : 0;
      r.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 85)) : 0;
      r.rst_at   = 0;
      r.code     = -1;
      do_line(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
